// File: rtl/mist_input_replay.sv
// -----------------------------------------------------------------------------
// mist_input_replay
//
// Frame-synchronised input player. Walks a table of {frame[15:0], word[DW-1:0]}
// events held behind a simple ROM request/acknowledge port and drives the game
// input bus with each word once the frame counter reaches that event's frame.
// With playback idle the live player inputs are passed through (one cycle of
// latency). Intended to sit between the joystick/coin mux and the game core
// for demo and regression replay.
//
// Parameters
//   AW        table address width; the table holds up to 2**AW events
//   DW        input word width; a table entry is DW+16 bits wide
//
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      synchronous reset, active low
//   enable     in   1      level; rising edge starts playback, low aborts
//   vs         in   1      vertical sync, synchronous to clk; falling edge = new frame
//   live_in    in   DW     live player inputs
//   rom_addr   out  AW     table entry address
//   rom_cs     out  1      table read request
//   rom_data   in   DW+16  table entry {frame, word}
//   rom_ok     in   1      rom_data valid for the current rom_addr
//   play_out   out  DW     inputs to the game core (registered)
//   active     out  1      playback in progress
//   done       out  1      table exhausted; sticky until enable goes low
//   frame_cnt  out  16     frames elapsed since playback start (saturates at FFFE)
//
// Build option
//   MIST_REPLAY_LOOP_EN  when defined, reaching the terminator (frame FFFF) or
//                        the last table address restarts playback from entry 0
//                        with the frame counter cleared instead of stopping.
// -----------------------------------------------------------------------------
module mist_input_replay #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             vs,
  input  logic [DW-1:0]    live_in,
  output logic [AW-1:0]    rom_addr,
  output logic             rom_cs,
  input  logic [DW+15:0]   rom_data,
  input  logic             rom_ok,
  output logic [DW-1:0]    play_out,
  output logic             active,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] ADDR_LAST  = '1;
  localparam logic [15:0]   FRAME_TERM = 16'hFFFF;
  localparam logic [15:0]   FRAME_SAT  = 16'hFFFE;

  state_e          state_q;
  logic [AW-1:0]   rom_addr_q;
  logic            rom_cs_q;
  logic            first_cs_q;   // set during the first cycle of each request
  logic            active_q;
  logic            done_q;
  logic [15:0]     frame_cnt_q;
  logic [DW-1:0]   play_out_q;
  logic [15:0]     ev_frame_q;
  logic [DW-1:0]   ev_word_q;
  logic            vs_l_q;
  logic            en_l_q;

  logic            vs_fall;
  logic            en_rise;
  logic            fetch_hit;
  logic            ev_due;
  logic            table_end;

  assign vs_fall = vs_l_q & ~vs;
  assign en_rise = enable & ~en_l_q;

  // A read completes only from the second request cycle on: an acknowledge
  // still asserted from the previous address must not be taken as valid.
  assign fetch_hit = (state_q == S_FETCH) && !first_cs_q && rom_ok;

  // Compare against the registered count, so a vsync falling edge in the same
  // cycle is not yet visible to the apply decision.
  assign ev_due = (frame_cnt_q >= ev_frame_q);

  // Terminator entry read, or the event at the last address just applied.
  assign table_end = (fetch_hit && (rom_data[DW+15:DW] == FRAME_TERM)) ||
                     ((state_q == S_HOLD) && ev_due && (rom_addr_q == ADDR_LAST));

  always_ff @(posedge clk) begin
    // The enable history follows the pin even while reset is held, so an
    // enable that is already high when reset releases does not start playback.
    en_l_q <= enable;

    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      rom_cs_q    <= 1'b0;
      first_cs_q  <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      play_out_q  <= '0;
      ev_frame_q  <= '0;
      ev_word_q   <= '0;
      vs_l_q      <= 1'b1;
    end else begin
      vs_l_q <= vs;

      if (active_q && vs_fall && (frame_cnt_q != FRAME_SAT)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end

      if ((state_q != S_IDLE) && !enable) begin
        // Abort: any acknowledge still in flight is simply never looked at.
        state_q    <= S_IDLE;
        rom_cs_q   <= 1'b0;
        first_cs_q <= 1'b0;
        active_q   <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            play_out_q <= live_in;
            if (en_rise) begin
              state_q     <= S_FETCH;
              rom_addr_q  <= '0;
              frame_cnt_q <= '0;
              done_q      <= 1'b0;
              active_q    <= 1'b1;
              rom_cs_q    <= 1'b1;
              first_cs_q  <= 1'b1;
            end
          end

          S_FETCH: begin
            if (first_cs_q) begin
              first_cs_q <= 1'b0;
            end else if (rom_ok) begin
              ev_frame_q <= rom_data[DW+15:DW];
              ev_word_q  <= rom_data[DW-1:0];
              rom_cs_q   <= 1'b0;
              state_q    <= S_HOLD;
            end
          end

          S_HOLD: begin
            if (ev_due) begin
              play_out_q <= ev_word_q;
              rom_addr_q <= rom_addr_q + 1'b1;
              state_q    <= S_FETCH;
              rom_cs_q   <= 1'b1;
              first_cs_q <= 1'b1;
            end
          end

          S_DONE: begin
            // Waits here, holding the last word, until enable drops.
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase

        // End of table overrides the per-state transitions above.
        if (table_end) begin
`ifdef MIST_REPLAY_LOOP_EN
          rom_addr_q  <= '0;
          frame_cnt_q <= '0;
          state_q     <= S_FETCH;
          rom_cs_q    <= 1'b1;
          first_cs_q  <= 1'b1;
`else
          rom_addr_q  <= rom_addr_q;
          state_q     <= S_DONE;
          rom_cs_q    <= 1'b0;
          first_cs_q  <= 1'b0;
          active_q    <= 1'b0;
          done_q      <= 1'b1;
`endif
        end
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  // Gated with reset so a reset in the middle of a fetch withdraws the
  // request in the same cycle rather than one clock later.
  assign rom_cs    = rom_cs_q & rst_n;
  assign play_out  = play_out_q;
  assign active    = active_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mist_input_replay.sv
// -----------------------------------------------------------------------------
// tb_mist_input_replay
//
// Directed bench for mist_input_replay (AW=2, DW=16). A small table model
// answers ROM requests either after a fixed latency or with a permanently
// asserted acknowledge. One initial block walks through reset, basic
// playback, same-frame events, stale acknowledge, abort, address wrap and
// reset during a fetch.
// -----------------------------------------------------------------------------
module tb_mist_input_replay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        vs;
  logic [15:0] live_in;
  logic [1:0]  rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [15:0] play_out;
  logic        active;
  logic        done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  mist_input_replay #(.AW(2), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .vs        (vs),
    .live_in   (live_in),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .play_out  (play_out),
    .active    (active),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Table model
  logic [31:0] rom [0:3];
  int          lat   = 2;
  bit          stale = 1'b0;
  int          rcnt  = 0;
  logic [1:0]  raddr_l = 2'd0;

  initial begin
    rom_ok   = 1'b0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      if (rom_cs !== 1'b1)          rcnt = 0;
      else if (rom_addr != raddr_l) rcnt = 1;
      else                          rcnt = rcnt + 1;
      raddr_l  = rom_addr;
      rom_data = rom[rom_addr];
      rom_ok   = stale ? 1'b1 : (rcnt >= lat);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse();
    vs = 1'b0;
    tick(2);
    vs = 1'b1;
    tick(3);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic load(input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  initial begin
    int   k;
    bit   seen;
    int   cs_len;

    rst_n   = 1'b0;
    enable  = 1'b1;
    vs      = 1'b1;
    live_in = 16'h1234;
    load(32'd0, 32'd0, 32'd0, 32'd0);

    // 1: reset with enable held high
    tick(3);
    chk("rst_play_out",  {16'd0, play_out}, 32'h0);
    chk("rst_rom_addr",  {30'd0, rom_addr}, 32'h0);
    chk("rst_rom_cs",    {31'd0, rom_cs},   32'h0);
    chk("rst_active",    {31'd0, active},   32'h0);
    chk("rst_done",      {31'd0, done},     32'h0);
    chk("rst_frame_cnt", {16'd0, frame_cnt},32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("t1_no_start_active", {31'd0, active}, 32'h0);
    chk("t1_no_start_cs",     {31'd0, rom_cs}, 32'h0);
    chk("t1_idle_follow",     {16'd0, play_out}, 32'h1234);

    // 2: basic playback, ok two cycles after request
    load({16'd0, 16'h0001}, {16'd3, 16'h0010}, {16'hFFFF, 16'h0000}, 32'd0);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    chk("t2_start_active", {31'd0, active}, 32'h1);
    chk("t2_start_cs",     {31'd0, rom_cs}, 32'h1);
    chk("t2_start_live",   {16'd0, play_out}, 32'h1234);
    tick(8);
    chk("t2_ev0_play",  {16'd0, play_out}, 32'h0001);
    chk("t2_ev0_addr",  {30'd0, rom_addr}, 32'h1);
    chk("t2_ev0_frame", {16'd0, frame_cnt}, 32'h0);
    vs_pulse();
    vs_pulse();
    chk("t2_f2_frame", {16'd0, frame_cnt}, 32'h2);
    chk("t2_f2_play",  {16'd0, play_out}, 32'h0001);
    vs_pulse();
    wait_done("t2_done", 20);
    chk("t2_end_play",   {16'd0, play_out}, 32'h0010);
    chk("t2_end_active", {31'd0, active}, 32'h0);
    chk("t2_end_frame",  {16'd0, frame_cnt}, 32'h3);
    chk("t2_end_addr",   {30'd0, rom_addr}, 32'h2);

    // 3: two events on the same frame
    enable = 1'b0;
    tick(1);
    chk("t3_done_clear", {31'd0, done}, 32'h0);
    load({16'd2, 16'hAAAA}, {16'd2, 16'h5555}, {16'hFFFF, 16'h0000}, 32'd0);
    live_in = 16'h0F0F;
    tick(1);
    enable = 1'b1;
    tick(10);
    chk("t3_wait_live", {16'd0, play_out}, 32'h0F0F);
    vs_pulse();
    chk("t3_f1_live",  {16'd0, play_out}, 32'h0F0F);
    chk("t3_f1_frame", {16'd0, frame_cnt}, 32'h1);
    seen = 1'b0;
    k = 0;
    vs = 1'b0;
    while (done !== 1'b1 && k < 30) begin
      tick(1);
      k++;
      if (k == 2) vs = 1'b1;
      if (play_out === 16'hAAAA) seen = 1'b1;
    end
    vs = 1'b1;
    chk("t3_done",      {31'd0, done}, 32'h1);
    chk("t3_transient", {31'd0, seen}, 32'h1);
    chk("t3_final",     {16'd0, play_out}, 32'h5555);
    chk("t3_addr",      {30'd0, rom_addr}, 32'h2);

    // 4: acknowledge permanently high
    enable = 1'b0;
    tick(2);
    stale = 1'b1;
    load({16'd0, 16'h0042}, {16'hFFFF, 16'h0000}, 32'd0, 32'd0);
    enable = 1'b1;
    tick(1);
    cs_len = 0;
    while (rom_cs === 1'b1 && cs_len < 10) begin
      cs_len++;
      tick(1);
    end
    chk("t4_cs_len", cs_len, 32'd2);
    wait_done("t4_done", 20);
    chk("t4_play", {16'd0, play_out}, 32'h0042);
    stale = 1'b0;

    // 5: abort while waiting for frame 10
    enable = 1'b0;
    tick(2);
    load({16'd0, 16'h0007}, {16'd10, 16'h0099}, {16'hFFFF, 16'h0000}, 32'd0);
    live_in = 16'h1234;
    enable = 1'b1;
    tick(10);
    chk("t5_ev0_play", {16'd0, play_out}, 32'h0007);
    repeat (4) vs_pulse();
    chk("t5_f4_frame",  {16'd0, frame_cnt}, 32'h4);
    chk("t5_f4_active", {31'd0, active}, 32'h1);
    enable  = 1'b0;
    live_in = 16'hBEEF;
    tick(1);
    chk("t5_abort_cs",     {31'd0, rom_cs}, 32'h0);
    chk("t5_abort_active", {31'd0, active}, 32'h0);
    chk("t5_abort_hold",   {16'd0, play_out}, 32'h0007);
    tick(1);
    chk("t5_abort_live",   {16'd0, play_out}, 32'hBEEF);
    chk("t5_abort_done",   {31'd0, done}, 32'h0);

    // 6: full table, no terminator, stops after the last address
    load({16'd0, 16'h1111}, {16'd1, 16'h2222}, {16'd2, 16'h3333}, {16'd3, 16'h4444});
    enable = 1'b1;
    tick(10);
    chk("t6_ev0_play", {16'd0, play_out}, 32'h1111);
    chk("t6_ev0_addr", {30'd0, rom_addr}, 32'h1);
    vs_pulse();
    tick(5);
    chk("t6_ev1_play", {16'd0, play_out}, 32'h2222);
    vs_pulse();
    tick(5);
    chk("t6_ev2_play", {16'd0, play_out}, 32'h3333);
    vs_pulse();
    wait_done("t6_done", 20);
    chk("t6_end_play",   {16'd0, play_out}, 32'h4444);
    chk("t6_end_addr",   {30'd0, rom_addr}, 32'h3);
    chk("t6_end_frame",  {16'd0, frame_cnt}, 32'h3);
    chk("t6_end_active", {31'd0, active}, 32'h0);

    // 7: reset during a fetch
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(1);
    chk("t7_fetch_cs", {31'd0, rom_cs}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t7_cs_drop", {31'd0, rom_cs}, 32'h0);
    tick(1);
    chk("t7_rst_active", {31'd0, active}, 32'h0);
    chk("t7_rst_play",   {16'd0, play_out}, 32'h0);
    chk("t7_rst_frame",  {16'd0, frame_cnt}, 32'h0);
    rst_n = 1'b1;
    tick(3);
    chk("t7_no_restart", {31'd0, active}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
